// File: rtl/i2c_slave_regfile.sv
// I2C target exposing a byte register file: pointer write, data write,
// and repeated-START reads, with a host port for preload and observation.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'b0010_000,
  parameter int          MEM_AW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  input  logic              host_we,
  input  logic [MEM_AW-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              wr_strobe,
  output logic              rd_strobe,
  output logic              busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [6:0]        tx_q, tx_d;
  logic              rw_q, rw_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic              sda_oe_q, sda_oe_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              mem_we;
  logic [7:0]        mem_q [2**MEM_AW];

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_s, sda_s;
  logic       start_det, stop_det, scl_rise, scl_fall;
  logic [7:0] byte_in;
  logic [7:0] mem_at_ptr;

  // Sync flops reset to the idle-bus level so release never fakes an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s      = scl_sync_q[1];
  assign sda_s      = sda_sync_q[1];
  assign start_det  = scl_s & sda_prev_q & ~sda_s;
  assign stop_det   = scl_s & ~sda_prev_q & sda_s;
  assign scl_rise   = scl_s & ~scl_prev_q;
  assign scl_fall   = ~scl_s & scl_prev_q;
  assign byte_in    = {shift_q, sda_s};
  assign mem_at_ptr = mem_q[ptr_q];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    mem_we    = 1'b0;
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == ADDR) begin
                if (byte_in[7:1] == SLAVE_ADDR) rw_d = byte_in[0];
                else state_d = WAIT_STOP;
              end
              if (state_q == WDATA) begin
                mem_we = 1'b1;
                wr_d   = 1'b1;
                ptr_d  = ptr_q + 1'b1;
              end
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d  = 1'b1;
            bit_cnt_d = 4'd0;
            if (state_q == ADDR) state_d = ADDR_ACK;
            else if (state_q == PTR) begin
              state_d = PTR_ACK;
              ptr_d   = shift_q[MEM_AW-1:0];
            end else state_d = WDATA_ACK;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              tx_d     = mem_at_ptr[6:0];
              sda_oe_d = ~mem_at_ptr[7];
              state_d  = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = PTR;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = WDATA;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = RDATA_ACK;
            end else begin
              tx_d      = {tx_q[5:0], 1'b0};
              sda_oe_d  = ~tx_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        RDATA_ACK: begin
          // bit_cnt==8 marks that the master's ACK has been sampled
          if (scl_rise && bit_cnt_q == 4'd0) begin
            rd_d  = 1'b1;
            ptr_d = ptr_q + 1'b1;
            if (sda_s) begin
              state_d  = WAIT_STOP;
              sda_oe_d = 1'b0;
            end else bit_cnt_d = 4'd8;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            tx_d      = mem_at_ptr[6:0];
            sda_oe_d  = ~mem_at_ptr[7];
            bit_cnt_d = 4'd0;
            state_d   = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 7'd0;
      tx_q      <= 7'd0;
      rw_q      <= 1'b0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      rw_q      <= rw_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
    end
  end

  // Bus write is applied last so it wins a same-address host collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**MEM_AW; i++) mem_q[i] <= 8'h00;
    end else begin
      if (host_we) mem_q[host_addr] <= host_wdata;
      if (mem_we) mem_q[ptr_q] <= byte_in;
    end
  end

  assign host_rdata = mem_q[host_addr];
  assign sda_oe     = sda_oe_q;
  assign wr_strobe  = wr_q;
  assign rd_strobe  = rd_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-level I2C master, register-file model,
// and a per-cycle compare process.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe;
  logic       host_we = 1'b0;
  logic       hw_act = 1'b0;
  logic [3:0] hw_addr = 4'd0;
  logic [3:0] sweep = 4'd0;
  logic [3:0] host_addr;
  logic [7:0] host_wdata = 8'h00;
  logic [7:0] host_rdata;
  logic       wr_strobe, rd_strobe, busy;
  wire        sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;
  always @(posedge clk) sweep <= sweep + 4'd1;
  assign host_addr = hw_act ? hw_addr : sweep;

  i2c_slave_regfile #(.SLAVE_ADDR(7'h10), .MEM_AW(4)) dut (
    .clk(clk), .rst(rst),
    .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
    .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
    .wr_strobe(wr_strobe), .rd_strobe(rd_strobe), .busy(busy)
  );

  logic [7:0] mdl_mem [16];
  logic [3:0] mdl_ptr = 4'd0;
  bit         mdl_valid = 1'b1;
  bit         quiet = 1'b0;
  int         checks = 0, errors = 0;
  int         wr_cnt = 0, rd_cnt = 0;
  logic       wr_prev = 1'b0, rd_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("strobe_excl", {31'd0, wr_strobe & rd_strobe}, 0);
      if (wr_strobe) begin
        chk("wr_width", {31'd0, wr_prev}, 0);
        wr_cnt++;
      end
      if (rd_strobe) begin
        chk("rd_width", {31'd0, rd_prev}, 0);
        rd_cnt++;
      end
      wr_prev = wr_strobe;
      rd_prev = rd_strobe;
      if (mdl_valid)
        chk("host_rdata", {24'd0, host_rdata}, {24'd0, mdl_mem[host_addr]});
      if (quiet) chk("quiet_sda_oe", {31'd0, sda_oe}, 0);
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    hw_act = 1'b1; hw_addr = a; host_wdata = d; host_we = 1'b1;
    @(posedge clk);
    #1;
    host_we = 1'b0; hw_act = 1'b0;
    mdl_mem[a] = d;
  endtask

  task automatic put_bit(input logic b);
    wclk(4); sda_m = b; wclk(4); scl_m = 1'b1; wclk(8); scl_m = 1'b0;
  endtask

  task automatic get_bit(output logic b);
    wclk(4); sda_m = 1'b1; wclk(4); scl_m = 1'b1;
    wclk(4); b = sda_bus; wclk(4); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    wclk(4); sda_m = 1'b1; wclk(4); scl_m = 1'b1;
    wclk(8); sda_m = 1'b0; wclk(8); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wclk(4); sda_m = 1'b0; wclk(4); scl_m = 1'b1;
    wclk(8); sda_m = 1'b1; wclk(8);
  endtask

  // is_wr: byte is data the addressed target must store at the pointer
  task automatic send_byte(input logic [7:0] b, input bit exp_ack,
                           input bit is_wr, input string nm);
    logic a;
    for (int i = 7; i >= 0; i--) begin
      if (is_wr && i == 0) mdl_valid = 1'b0;
      put_bit(b[i]);
    end
    get_bit(a);
    chk({nm, "_ack"}, {31'd0, a}, exp_ack ? 0 : 1);
    if (is_wr) begin
      mdl_mem[mdl_ptr] = b;
      mdl_ptr++;
      mdl_valid = 1'b1;
    end
  endtask

  task automatic send_addr(input logic [7:0] b, input string nm);
    send_byte(b, b[7:1] == 7'h10, 1'b0, nm);
  endtask

  task automatic send_ptr(input logic [7:0] p, input string nm);
    send_byte(p, 1'b1, 1'b0, nm);
    mdl_ptr = p[3:0];
  endtask

  task automatic recv_byte(input bit ack, output logic [7:0] v,
                           input string nm);
    logic bb;
    for (int i = 7; i >= 0; i--) begin
      get_bit(bb);
      v[i] = bb;
    end
    chk(nm, {24'd0, v}, {24'd0, mdl_mem[mdl_ptr]});
    mdl_ptr++;
    put_bit(ack ? 1'b0 : 1'b1);
  endtask

  task automatic scen1(input string tag, input logic [7:0] exp7);
    logic [7:0] v;
    int w0;
    host_write(4'd6, 8'h3C);
    host_write(4'd7, exp7);
    w0 = wr_cnt;
    i2c_start();
    send_addr(8'h20, {tag, "_addr"});
    send_ptr(8'h06, {tag, "_ptr"});
    send_byte(8'hA5, 1'b1, 1'b1, {tag, "_data"});
    i2c_stop();
    chk({tag, "_wr_cnt"}, wr_cnt - w0, 1);
    chk({tag, "_busy_idle"}, {31'd0, busy}, 0);
    chk({tag, "_mem6"}, {24'd0, mdl_mem[6]}, 32'hA5);
    // current-address read exposes the post-increment pointer
    i2c_start();
    send_addr(8'h21, {tag, "_raddr"});
    recv_byte(1'b0, v, {tag, "_cur_rd"});
    chk({tag, "_ptr7_lit"}, {24'd0, v}, {24'd0, exp7});
    i2c_stop();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int r0, w0;
    for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
    wclk(4);
    rst = 1'b0;
    wclk(2);
    chk("rst_sda_oe", {31'd0, sda_oe}, 0);
    chk("rst_wr", {31'd0, wr_strobe}, 0);
    chk("rst_rd", {31'd0, rd_strobe}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    wclk(20);

    scen1("t1", 8'h5E);

    r0 = rd_cnt;
    i2c_start();
    send_addr(8'h20, "t2_addr");
    send_ptr(8'h06, "t2_ptr");
    i2c_start();
    send_addr(8'h21, "t2_raddr");
    recv_byte(1'b0, v, "t2_rd");
    chk("t2_rd_lit", {24'd0, v}, 32'hA5);
    chk("t2_rd_cnt", rd_cnt - r0, 1);
    quiet = 1'b1;
    wclk(6);
    chk("t2_wait_busy", {31'd0, busy}, 1);
    put_bit(1'b1);
    chk("t2_wait_busy2", {31'd0, busy}, 1);
    i2c_stop();
    quiet = 1'b0;
    chk("t2_stop_busy", {31'd0, busy}, 0);

    quiet = 1'b1;
    w0 = wr_cnt;
    i2c_start();
    send_addr(8'h40, "t3_addr");
    send_byte(8'h06, 1'b0, 1'b0, "t3_b1");
    send_byte(8'h55, 1'b0, 1'b0, "t3_b2");
    chk("t3_busy", {31'd0, busy}, 1);
    i2c_stop();
    quiet = 1'b0;
    chk("t3_busy_end", {31'd0, busy}, 0);
    chk("t3_wr_cnt", wr_cnt - w0, 0);
    i2c_start();
    send_addr(8'h21, "t3_raddr");
    recv_byte(1'b0, v, "t3_cur_rd");
    i2c_stop();

    host_write(4'd15, 8'h11);
    host_write(4'd0, 8'h22);
    host_write(4'd1, 8'h77);
    r0 = rd_cnt;
    i2c_start();
    send_addr(8'h20, "t4_addr");
    send_ptr(8'h0F, "t4_ptr");
    i2c_start();
    send_addr(8'h21, "t4_raddr");
    recv_byte(1'b1, v, "t4_rd0");
    chk("t4_rd0_lit", {24'd0, v}, 32'h11);
    recv_byte(1'b0, v, "t4_rd1");
    chk("t4_rd1_lit", {24'd0, v}, 32'h22);
    i2c_stop();
    chk("t4_rd_cnt", rd_cnt - r0, 2);
    i2c_start();
    send_addr(8'h21, "t4_raddr2");
    recv_byte(1'b0, v, "t4_cur_rd");
    chk("t4_ptr1_lit", {24'd0, v}, 32'h77);
    i2c_stop();

    w0 = wr_cnt;
    i2c_start();
    send_addr(8'h20, "t5_addr");
    send_ptr(8'h03, "t5_ptr");
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
    i2c_stop();
    chk("t5_wr_cnt", wr_cnt - w0, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    chk("t5_sda_oe", {31'd0, sda_oe}, 0);
    wclk(20);

    host_write(4'd3, 8'h5A);
    i2c_start();
    send_addr(8'h20, "t6_addr");
    send_ptr(8'h03, "t6_ptr");
    i2c_start();
    send_addr(8'h21, "t6_raddr");
    wclk(6);
    chk("t6_drive0", {31'd0, sda_oe}, 1);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
    mdl_ptr = 4'd0;
    #1;
    chk("t6_rst_sda_oe", {31'd0, sda_oe}, 0);
    chk("t6_rst_rdata", {24'd0, host_rdata}, 0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    wclk(4);
    rst = 1'b0;
    wclk(20);
    chk("t6_busy", {31'd0, busy}, 0);
    scen1("t6b", 8'h00);
    host_write(4'd7, 8'h00);
    wclk(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
